fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the MIPS core: PC register, sequential incrementer, branch/jump/jr target generation, variable-latency instruction-memory handshake and a DEPTH-entry instruction queue. Sits between the instruction ROM and the decode/control path, replacing a hardwired PC-to-ROM connection with a fetch path that tolerates memory latency and downstream stalls and redirects cleanly.

---
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction-fetch front end (PC, redirect targets, imem handshake, DEPTH-entry queue).
// Optional FETCH_PERF_CNT_EN adds pop and redirect counters.
module fetch_unit #(
  parameter int          ADDR_W   = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_out,
  output logic [ADDR_W-1:0] imem_addr_out,
  input  logic              imem_gnt_in,
  input  logic              imem_rsp_valid_in,
  input  logic [31:0]       imem_data_in,
  output logic              inst_valid_out,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] inst_pc_out,
  input  logic              inst_ready_in,
  input  logic [ADDR_W-1:0] redirect_base_in,
  input  logic              branch_en_in,
  input  logic [15:0]       branch_imm_in,
  input  logic              jump_en_in,
  input  logic [25:0]       jump_idx_in,
  input  logic              jr_en_in,
  input  logic [ADDR_W-1:0] jr_target_in
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt_out,
  output logic [31:0]       perf_flush_cnt_out
`endif
);

  localparam int                PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W      = PTR_W + 1;
  localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] RESET_ADDR = {RESET_PC[ADDR_W-1:2], 2'b00};

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              pending;
  logic              discard;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [31:0]       q_inst [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic [CNT_W:0]    occupancy;
  logic              grant;
  logic              push;
  logic              pop;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] base,
                                                      input logic signed [15:0] imm);
    logic signed [ADDR_W-1:0] offset;
    offset = ADDR_W'(imm) <<< 2;
    return align_word(base + PC_INC + $unsigned(offset));
  endfunction

  // Region bits come from the delay-slot address, not the jump itself.
  function automatic logic [ADDR_W-1:0] jump_target(input logic [ADDR_W-1:0] base,
                                                    input logic [25:0] idx);
    logic [ADDR_W-1:0] t;
    t       = base + PC_INC;
    t[27:0] = {idx, 2'b00};
    return t;
  endfunction

  always_comb begin
    redirect = jr_en_in | jump_en_in | branch_en_in;
    target   = branch_target(redirect_base_in, branch_imm_in);
    if (jr_en_in)
      target = align_word(jr_target_in);
    else if (jump_en_in)
      target = jump_target(redirect_base_in, jump_idx_in);
  end

  // Issue: one request in flight; the occupancy guard reserves a queue slot
  // for every outstanding response, so a push never finds the queue full.
  assign occupancy     = {1'b0, count} + {{CNT_W{1'b0}}, pending};
  assign imem_req_out  = !reset && !redirect && (!pending || imem_rsp_valid_in) &&
                         (occupancy < DEPTH_C);
  assign imem_addr_out = fetch_pc;
  assign grant         = imem_req_out && imem_gnt_in;
  assign push          = imem_rsp_valid_in && !discard && !redirect;
  assign pop           = inst_valid_out && inst_ready_in && !redirect;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_ADDR;
      pending  <= 1'b0;
      discard  <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (redirect)
        fetch_pc <= target;
      else if (grant)
        fetch_pc <= fetch_pc + PC_INC;

      if (grant)
        pending <= 1'b1;
      else if (imem_rsp_valid_in)
        pending <= 1'b0;

      // Any response consumes the stale marker; a redirect with the
      // response still outstanding marks it stale.
      if (imem_rsp_valid_in)
        discard <= 1'b0;
      else if (redirect && pending)
        discard <= 1'b1;

      if (redirect) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push)
          tail <= tail + PTR_W'(1);
        if (pop)
          head <= head + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage and the in-flight request address carry no reset.
  always_ff @(posedge clock) begin
    if (grant)
      req_pc <= fetch_pc;
    if (push) begin
      q_inst[tail] <= imem_data_in;
      q_pc[tail]   <= req_pc;
    end
  end

  assign inst_valid_out = (count != '0);
  assign inst_out       = inst_valid_out ? q_inst[head] : 32'd0;
  assign inst_pc_out    = inst_valid_out ? q_pc[head]   : '0;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt_out <= 32'd0;
      perf_flush_cnt_out <= 32'd0;
    end else begin
      if (pop)
        perf_fetch_cnt_out <= perf_fetch_cnt_out + 32'd1;
      if (redirect)
        perf_flush_cnt_out <= perf_flush_cnt_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a stream-level
// reference model (expected fetch/pop addresses, queue occupancy, request epochs).
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int          ADDR_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rsp_valid_in;
  logic [31:0] imem_data_in;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_out;
  logic        inst_ready_in;
  logic [31:0] redirect_base_in;
  logic        branch_en_in;
  logic [15:0] branch_imm_in;
  logic        jump_en_in;
  logic [25:0] jump_idx_in;
  logic        jr_en_in;
  logic [31:0] jr_target_in;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_out;
  logic [31:0] perf_flush_cnt_out;
`endif

  fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_gnt_in(imem_gnt_in), .imem_rsp_valid_in(imem_rsp_valid_in),
    .imem_data_in(imem_data_in),
    .inst_valid_out(inst_valid_out), .inst_out(inst_out), .inst_pc_out(inst_pc_out),
    .inst_ready_in(inst_ready_in),
    .redirect_base_in(redirect_base_in),
    .branch_en_in(branch_en_in), .branch_imm_in(branch_imm_in),
    .jump_en_in(jump_en_in), .jump_idx_in(jump_idx_in),
    .jr_en_in(jr_en_in), .jr_target_in(jr_target_in)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt_out(perf_fetch_cnt_out), .perf_flush_cnt_out(perf_flush_cnt_out)
`endif
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Memory model: at most one outstanding request, tagged with the redirect epoch.
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_due;
  int          mem_epoch;
  int          epoch = 0;

  // Reference stream state.
  int          occ;
  logic [31:0] exp_fetch;
  logic [31:0] exp_pop;

  // Stimulus knobs.
  logic        k_rand = 1'b0;
  logic        k_gnt, k_ready;
  int          k_lat;
  logic        k_br = 1'b0, k_j = 1'b0, k_jr = 1'b0;
  logic [31:0] k_base = '0, k_tgt = '0;
  logic [15:0] k_imm = '0;
  logic [25:0] k_idx = '0;

  // Values sampled in the most recent step.
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_inst, s_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ref_target(input logic br, input logic j, input logic jr,
                                             input logic [31:0] base, input logic [15:0] imm,
                                             input logic [25:0] idx, input logic [31:0] tgt);
    int off;
    if (jr) return tgt & ~32'd3;
    if (j)  return ((base + 32'd4) & 32'hF000_0000) | ({6'd0, idx} << 2);
    off = int'($signed(imm)) * 4;
    return base + 32'd4 + 32'(off);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_redirect();
    k_br = 1'b0; k_j = 1'b0; k_jr = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    imem_gnt_in = 1'b0; imem_rsp_valid_in = 1'b0; imem_data_in = '0;
    inst_ready_in = 1'b0; branch_en_in = 1'b0; jump_en_in = 1'b0; jr_en_in = 1'b0;
    redirect_base_in = '0; branch_imm_in = '0; jump_idx_in = '0; jr_target_in = '0;
    #1;
    check({tag, "_req"},   {31'd0, imem_req_out},   32'd0);
    check({tag, "_valid"}, {31'd0, inst_valid_out}, 32'd0);
    check({tag, "_inst"},  inst_out,                32'd0);
    check({tag, "_pc"},    inst_pc_out,             32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    mem_busy = 1'b0; occ = 0; epoch++;
    exp_fetch = RESET_PC; exp_pop = RESET_PC;
    clear_redirect();
  endtask

  // One clock cycle: drive at posedge+1, sample and model at the falling edge.
  task automatic step();
    logic rsp_now, redir, popped;
    if (k_rand) begin
      k_gnt   = ($urandom_range(0, 3) != 0);
      k_ready = ($urandom_range(0, 3) != 0);
      k_lat   = $urandom_range(1, 3);
      clear_redirect();
      if ($urandom_range(0, 11) == 0) begin
        k_br = $urandom_range(0, 1); k_j = $urandom_range(0, 1); k_jr = $urandom_range(0, 1);
        k_base = $urandom & ~32'd3; k_imm = 16'($urandom);
        k_idx = 26'($urandom); k_tgt = $urandom;
      end
    end
    rsp_now = mem_busy && (mem_due == cyc);
    redir   = k_br | k_j | k_jr;
    imem_rsp_valid_in = rsp_now;
    imem_data_in      = rsp_now ? inst_of(mem_addr) : $urandom;
    imem_gnt_in       = k_gnt;
    inst_ready_in     = k_ready;
    branch_en_in = k_br; jump_en_in = k_j; jr_en_in = k_jr;
    redirect_base_in = k_base; branch_imm_in = k_imm; jump_idx_in = k_idx; jr_target_in = k_tgt;
    @(negedge clock);
    s_req = imem_req_out; s_addr = imem_addr_out;
    s_valid = inst_valid_out; s_inst = inst_out; s_pc = inst_pc_out;

    check("req_rule", {31'd0, s_req},
          {31'd0, !redir && (!mem_busy || rsp_now) && ((occ + int'(mem_busy)) < DEPTH)});
    if (s_req) check("req_addr", s_addr, exp_fetch);
    check("head_valid", {31'd0, s_valid}, {31'd0, occ != 0});
    popped = s_valid && k_ready && !redir;
    if (popped) begin
      check("pop_pc", s_pc, exp_pop);
      check("pop_inst", s_inst, inst_of(exp_pop));
      exp_pop += 32'd4;
      occ--;
    end
    if (rsp_now) begin
      mem_busy = 1'b0;
      if (!redir && mem_epoch == epoch) occ++;
    end
    if (s_req && k_gnt) begin
      mem_busy = 1'b1; mem_addr = s_addr; mem_due = cyc + k_lat; mem_epoch = epoch;
      exp_fetch += 32'd4;
    end
    if (redir) begin
      exp_fetch = ref_target(k_br, k_j, k_jr, k_base, k_imm, k_idx, k_tgt);
      exp_pop   = exp_fetch;
      occ       = 0;
      epoch++;
    end
    if (!k_rand) clear_redirect();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    step();
    while (!s_req && n < 12) begin
      step();
      n++;
    end
    check(tag, {31'd0, s_req}, 32'd1);
  endtask

  initial begin
    int grants;
    // Reset release, streaming with a 1-cycle memory.
    do_reset("rst0");
    k_gnt = 1'b1; k_ready = 1'b1; k_lat = 1;
    step(); check("A_req0", {31'd0, s_req}, 32'd1); check("A_addr0", s_addr, 32'h0040_0000);
            check("A_vld0", {31'd0, s_valid}, 32'd0);
    step(); check("A_addr1", s_addr, 32'h0040_0004); check("A_vld1", {31'd0, s_valid}, 32'd0);
    step(); check("A_addr2", s_addr, 32'h0040_0008); check("A_vld2", {31'd0, s_valid}, 32'd1);
            check("A_pc2", s_pc, 32'h0040_0000);
    step(); check("A_pc3", s_pc, 32'h0040_0004); check("A_vld3", {31'd0, s_valid}, 32'd1);

    // Consumer stalled: exactly DEPTH entries accepted, then resume after first pop.
    do_reset("rst1");
    k_gnt = 1'b1; k_ready = 1'b0; k_lat = 1;
    grants = 0;
    repeat (8) begin
      step();
      if (s_req) grants++;
    end
    check("B_grants", grants, 32'd4);
    check("B_req_full", {31'd0, s_req}, 32'd0);
    k_ready = 1'b1;
    step(); check("B_req_popcyc", {31'd0, s_req}, 32'd0);
    step(); check("B_req_resume", {31'd0, s_req}, 32'd1);
            check("B_addr_resume", s_addr, 32'h0040_0010);

    // Branch while a slow request is pending: flush, stale word dropped.
    do_reset("rst2");
    k_gnt = 1'b1; k_ready = 1'b0; k_lat = 1;
    step(); step();
    k_lat = 3;
    step();
    k_lat = 1; k_br = 1'b1; k_base = 32'h0040_0010; k_imm = 16'hFFFC;
    step(); check("C_req_redir", {31'd0, s_req}, 32'd0);
            check("C_vld_before", {31'd0, s_valid}, 32'd1);
    step(); check("C_vld_flushed", {31'd0, s_valid}, 32'd0);
    wait_req("C_req_seen");
    check("C_target", s_addr, 32'h0040_0004);
    k_ready = 1'b1;

    // All three redirect sources at once: jr wins, low bits cleared.
    k_jr = 1'b1; k_j = 1'b1; k_br = 1'b1;
    k_tgt = 32'h0040_0103; k_base = 32'h0040_0020; k_idx = 26'h123456; k_imm = 16'h0008;
    step();
    wait_req("D_req_seen");
    check("D_target", s_addr, 32'h0040_0100);

    // PC wraps at the top of the address space.
    k_jr = 1'b1; k_tgt = 32'hFFFF_FFFC;
    step();
    wait_req("E_req_seen");
    check("E_top", s_addr, 32'hFFFF_FFFC);
    step();
    check("E_wrap_req", {31'd0, s_req}, 32'd1);
    check("E_wrap", s_addr, 32'h0000_0000);

    // Asynchronous reset with three entries queued.
    do_reset("rst3");
    k_gnt = 1'b1; k_ready = 1'b0; k_lat = 1;
    repeat (4) step();
    check("F_vld_pre", {31'd0, s_valid}, 32'd1);
    do_reset("F_async");
    k_ready = 1'b1;
    step(); check("F_req_restart", {31'd0, s_req}, 32'd1);
            check("F_addr_restart", s_addr, RESET_PC);

    // Randomized traffic against the stream model.
    k_rand = 1'b1;
    repeat (3000) step();
    k_rand = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
